// File: rtl/rv32i_lsu.sv
// Load/store unit: turns a core memory request into one word-aligned bus transaction,
// stalls the core until it completes, and reports misalignment or bus timeout as a fault.
module rv32i_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  core_op,
  input  logic [1:0]  core_size,
  input  logic        core_unsigned,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  output logic        core_stall,
  output logic [31:0] core_rdata,
  output logic        core_rdata_valid,
  output logic        core_fault,
  output logic [1:0]  core_fault_cause,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic        TO_EN = (TIMEOUT_CYCLES != 0);

  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [1:0] CAUSE_LD_MIS  = 2'b01;
  localparam logic [1:0] CAUSE_ST_MIS  = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_REQ   = 2'b01,
    S_DONE  = 2'b10,
    S_FAULT = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bus_req_q, bus_req_d;
  logic             bus_we_q, bus_we_d;
  logic [31:0]      bus_addr_q, bus_addr_d;
  logic [3:0]       bus_be_q, bus_be_d;
  logic [31:0]      bus_wdata_q, bus_wdata_d;
  logic [1:0]       size_q, size_d;
  logic             uns_q, uns_d;
  logic [1:0]       off_q, off_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             rdata_valid_q, rdata_valid_d;
  logic             fault_q, fault_d;
  logic [1:0]       cause_q, cause_d;
  logic             core_stall_c;

  logic             req_load, req_store, req_any;
  logic             misaligned;
  logic             timeout_hit;
  logic [CNT_W-1:0] cnt_inc;
  logic [3:0]       be_new;
  logic [31:0]      wdata_new;
  logic [7:0]       lane_b;
  logic [15:0]      lane_h;
  logic [31:0]      load_ext;

  assign req_load  = (core_op == OP_LOAD);
  assign req_store = (core_op == OP_STORE);
  assign req_any   = req_load | req_store;

  assign cnt_inc     = cnt_q + CNT_W'(1);
  assign timeout_hit = TO_EN && (cnt_inc == CNT_W'(TIMEOUT_CYCLES));

  // Alignment check; the reserved size always faults.
  always_comb begin
    case (core_size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = core_addr[0];
      SZ_WORD: misaligned = |core_addr[1:0];
      default: misaligned = 1'b1;
    endcase
  end

  // Lane enables and lane-replicated store data for the incoming request.
  always_comb begin
    be_new    = 4'b0000;
    wdata_new = core_wdata;
    case (core_size)
      SZ_BYTE: begin
        be_new    = 4'b0001 << core_addr[1:0];
        wdata_new = {4{core_wdata[7:0]}};
      end
      SZ_HALF: begin
        be_new    = core_addr[1] ? 4'b1100 : 4'b0011;
        wdata_new = {2{core_wdata[15:0]}};
      end
      default: begin
        be_new    = 4'b1111;
        wdata_new = core_wdata;
      end
    endcase
  end

  // Pick the addressed lane out of the read word and extend it.
  always_comb begin
    case (off_q)
      2'd0:    lane_b = bus_rdata[7:0];
      2'd1:    lane_b = bus_rdata[15:8];
      2'd2:    lane_b = bus_rdata[23:16];
      default: lane_b = bus_rdata[31:24];
    endcase
    lane_h = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (size_q)
      SZ_BYTE: load_ext = {{24{lane_b[7] & ~uns_q}}, lane_b};
      SZ_HALF: load_ext = {{16{lane_h[15] & ~uns_q}}, lane_h};
      default: load_ext = bus_rdata;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; an ack wins over a timeout landing in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_any) begin
          state_d = misaligned ? S_FAULT : S_REQ;
        end
      end
      S_REQ: begin
        if (bus_ack) begin
          state_d = S_DONE;
        end else if (timeout_hit) begin
          state_d = S_FAULT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values; pulses default low every cycle.
  always_comb begin
    core_stall_c  = 1'b0;
    cnt_d         = cnt_q;
    bus_req_d     = bus_req_q;
    bus_we_d      = bus_we_q;
    bus_addr_d    = bus_addr_q;
    bus_be_d      = bus_be_q;
    bus_wdata_d   = bus_wdata_q;
    size_d        = size_q;
    uns_d         = uns_q;
    off_d         = off_q;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    fault_d       = 1'b0;
    cause_d       = 2'b00;
    case (state_q)
      S_IDLE: begin
        if (req_any) begin
          core_stall_c = 1'b1;
          if (misaligned) begin
            fault_d = 1'b1;
            cause_d = req_load ? CAUSE_LD_MIS : CAUSE_ST_MIS;
          end else begin
            bus_req_d   = 1'b1;
            bus_we_d    = req_store;
            bus_addr_d  = {core_addr[31:2], 2'b00};
            bus_be_d    = be_new;
            bus_wdata_d = wdata_new;
            size_d      = core_size;
            uns_d       = core_unsigned;
            off_d       = core_addr[1:0];
            cnt_d       = '0;
          end
        end
      end
      S_REQ: begin
        core_stall_c = 1'b1;
        cnt_d        = cnt_inc;
        if (bus_ack) begin
          bus_req_d = 1'b0;
          if (!bus_we_q) begin
            rdata_d       = load_ext;
            rdata_valid_d = 1'b1;
          end
        end else if (timeout_hit) begin
          bus_req_d = 1'b0;
          fault_d   = 1'b1;
          cause_d   = CAUSE_TIMEOUT;
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q         <= '0;
      bus_req_q     <= 1'b0;
      bus_we_q      <= 1'b0;
      bus_addr_q    <= 32'h0;
      bus_be_q      <= 4'h0;
      bus_wdata_q   <= 32'h0;
      size_q        <= 2'b00;
      uns_q         <= 1'b0;
      off_q         <= 2'b00;
      rdata_q       <= 32'h0;
      rdata_valid_q <= 1'b0;
      fault_q       <= 1'b0;
      cause_q       <= 2'b00;
    end else begin
      cnt_q         <= cnt_d;
      bus_req_q     <= bus_req_d;
      bus_we_q      <= bus_we_d;
      bus_addr_q    <= bus_addr_d;
      bus_be_q      <= bus_be_d;
      bus_wdata_q   <= bus_wdata_d;
      size_q        <= size_d;
      uns_q         <= uns_d;
      off_q         <= off_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      fault_q       <= fault_d;
      cause_q       <= cause_d;
    end
  end

  assign core_stall       = core_stall_c;
  assign core_rdata       = rdata_q;
  assign core_rdata_valid = rdata_valid_q;
  assign core_fault       = fault_q;
  assign core_fault_cause = cause_q;
  assign bus_req          = bus_req_q;
  assign bus_we           = bus_we_q;
  assign bus_addr         = bus_addr_q;
  assign bus_be           = bus_be_q;
  assign bus_wdata        = bus_wdata_q;

endmodule

// File: tb/tb_rv32i_lsu.sv
// Bench for rv32i_lsu: byte-level memory reference model, a bus slave with programmable
// wait states, and scoreboards for both the bus side and the core response side.
module tb_rv32i_lsu;

  localparam int unsigned TO   = 4;
  localparam logic [31:0] BASE = 32'h8000_1000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  core_op = 2'b00;
  logic [1:0]  core_size = 2'b00;
  logic        core_unsigned = 1'b0;
  logic [31:0] core_addr = 32'h0;
  logic [31:0] core_wdata = 32'h0;
  logic        core_stall;
  logic [31:0] core_rdata;
  logic        core_rdata_valid;
  logic        core_fault;
  logic [1:0]  core_fault_cause;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = 32'h0;

  rv32i_lsu #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .core_op(core_op), .core_size(core_size), .core_unsigned(core_unsigned),
    .core_addr(core_addr), .core_wdata(core_wdata),
    .core_stall(core_stall), .core_rdata(core_rdata), .core_rdata_valid(core_rdata_valid),
    .core_fault(core_fault), .core_fault_cause(core_fault_cause),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        fault;
    bit [1:0]  cause;
    bit [31:0] rdata;
  } resp_t;

  typedef struct {
    bit        we;
    bit [31:0] addr;
    bit [3:0]  be;
    bit [31:0] wdata;
  } bus_t;

  resp_t     resp_q[$];
  bus_t      bus_q[$];
  bit [7:0]  rmem [bit [31:0]];
  bit [31:0] smem [bit [31:0]];
  bit [31:0] last_load = 32'h0;
  int        n_tests = 0;
  int        n_fail = 0;
  int        slave_wait = 0;
  bit        slave_hold = 1'b0;
  bit        slave_late = 1'b0;
  int        req_age = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void preload(input bit [31:0] a, input bit [31:0] v);
    smem[a] = v;
    for (int i = 0; i < 4; i++) rmem[a + 32'(i)] = 8'(v >> (8 * i));
  endfunction

  // Bus slave plus response monitor, both sampling on the falling edge.
  always @(negedge clk) begin
    bus_t      e;
    resp_t     r;
    bit [31:0] mask;
    bit [31:0] tmp;
    bus_ack = 1'b0;
    if (!reset_n) begin
      req_age = 0;
    end else begin
      if (slave_late) begin
        bus_ack = 1'b1;
      end else if (bus_req && !slave_hold) begin
        if (req_age < slave_wait) begin
          req_age++;
        end else begin
          bus_ack = 1'b1;
          req_age = 0;
          if (bus_q.size() == 0) begin
            check("bus_unexpected_req", 32'(bus_req), 32'd0);
          end else begin
            e = bus_q.pop_front();
            check("bus_we", 32'(bus_we), 32'(e.we));
            check("bus_addr", bus_addr, e.addr);
            check("bus_be", 32'(bus_be), 32'(e.be));
            if (e.we) check("bus_wdata", bus_wdata, e.wdata);
          end
          if (bus_we) begin
            mask = {{8{bus_be[3]}}, {8{bus_be[2]}}, {8{bus_be[1]}}, {8{bus_be[0]}}};
            tmp = smem[bus_addr];
            smem[bus_addr] = (tmp & ~mask) | (bus_wdata & mask);
          end else begin
            bus_rdata = smem[bus_addr];
          end
        end
      end else if (!bus_req) begin
        req_age = 0;
      end

      if (core_rdata_valid || core_fault) begin
        if (resp_q.size() == 0) begin
          check("resp_unexpected_pulse", {30'd0, core_rdata_valid, core_fault}, 32'd0);
        end else begin
          r = resp_q.pop_front();
          check("resp_valid", 32'(core_rdata_valid), 32'(!r.fault));
          check("resp_fault", 32'(core_fault), 32'(r.fault));
          check("resp_cause", 32'(core_fault_cause), 32'(r.cause));
          check("resp_rdata", core_rdata, r.rdata);
        end
      end
    end
  end

  // One core request from issue to commit; expectations come from the byte-level model.
  task automatic access(input bit [1:0] op, input bit [1:0] size, input bit uns,
                        input bit [31:0] addr, input bit [31:0] wdata,
                        input int waits, input bit hold);
    int        n;
    bit        mis, is_ld, is_st, done;
    int        stall_cnt, req_cnt, exp_stall, exp_req;
    resp_t     r;
    bus_t      b;
    bit [31:0] v;
    @(negedge clk);
    is_ld = (op == 2'b01);
    is_st = (op == 2'b10);
    n     = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    mis   = (size == 2'b11) || ((addr % 32'(n)) != 0);
    slave_wait = waits;
    slave_hold = hold;
    core_op = op; core_size = size; core_unsigned = uns; core_addr = addr; core_wdata = wdata;
    exp_stall = 0;
    exp_req   = 0;
    if (is_ld || is_st) begin
      if (mis) begin
        r.fault = 1'b1; r.cause = is_ld ? 2'b01 : 2'b10; r.rdata = last_load;
        resp_q.push_back(r);
        exp_stall = 1;
      end else if (hold) begin
        r.fault = 1'b1; r.cause = 2'b11; r.rdata = last_load;
        resp_q.push_back(r);
        exp_stall = 1 + TO;
        exp_req   = TO;
      end else begin
        b.we    = is_st;
        b.addr  = addr & ~32'd3;
        b.be    = 4'(((32'd1 << n) - 32'd1) << addr[1:0]);
        b.wdata = 32'h0;
        for (int k = 0; k < 4; k++) b.wdata = b.wdata | (32'(8'(wdata >> (8 * (k % n)))) << (8 * k));
        bus_q.push_back(b);
        if (is_st) begin
          for (int i = 0; i < n; i++) rmem[addr + 32'(i)] = 8'(wdata >> (8 * i));
        end else begin
          v = 32'h0;
          for (int i = 0; i < n; i++) v = v | (32'(rmem[addr + 32'(i)]) << (8 * i));
          if (!uns && n < 4 && ((v >> (8 * n - 1)) & 32'd1) != 0) v = v | (32'hFFFF_FFFF << (8 * n));
          r.fault = 1'b0; r.cause = 2'b00; r.rdata = v;
          resp_q.push_back(r);
          last_load = v;
        end
        exp_stall = 2 + waits;
        exp_req   = 1 + waits;
      end
    end
    stall_cnt = 0; req_cnt = 0; done = 1'b0;
    for (int c = 0; c < 24; c++) begin
      #1;
      if (bus_req) req_cnt++;
      if (!core_stall) begin
        done = 1'b1;
        break;
      end
      stall_cnt++;
      @(negedge clk);
    end
    check("access_completes", 32'(done), 32'd1);
    check("stall_cycles", 32'(stall_cnt), 32'(exp_stall));
    check("bus_req_cycles", 32'(req_cnt), 32'(exp_req));
    check("done_valid", 32'(core_rdata_valid), 32'(is_ld && !mis && !hold));
    check("done_fault", 32'(core_fault), 32'((is_ld || is_st) && (mis || hold)));
    core_op = 2'b00;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int w = 0; w < 24; w++) preload(BASE + 32'(4 * w), $urandom);
    preload(32'h8000_1004, 32'hDEAD_BEEF);
    preload(32'h8000_1008, 32'h80A5_5A5A);

    repeat (3) @(negedge clk);
    #1;
    check("rst_stall", 32'(core_stall), 32'd0);
    check("rst_bus_req", 32'(bus_req), 32'd0);
    check("rst_bus_addr", bus_addr, 32'h0);
    check("rst_bus_be", 32'(bus_be), 32'h0);
    check("rst_rdata", core_rdata, 32'h0);
    check("rst_fault_cause", 32'(core_fault_cause), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    access(2'b01, 2'b10, 1'b0, 32'h8000_1004, 32'h0, 0, 1'b0);          // LW zero-wait
    access(2'b01, 2'b00, 1'b0, 32'h8000_100B, 32'h0, 1, 1'b0);          // LB lane 3
    access(2'b01, 2'b00, 1'b1, 32'h8000_100B, 32'h0, 0, 1'b0);          // LBU lane 3
    access(2'b10, 2'b01, 1'b0, 32'h8000_1012, 32'h1234_ABCD, 3, 1'b0);  // SH, 3 waits
    access(2'b01, 2'b10, 1'b0, 32'h8000_1010, 32'h0, 0, 1'b0);          // read it back
    access(2'b10, 2'b10, 1'b0, 32'h8000_1001, 32'h5555_AAAA, 0, 1'b0);  // SW misaligned
    access(2'b01, 2'b01, 1'b0, 32'h8000_1003, 32'h0, 0, 1'b0);          // LH misaligned
    access(2'b11, 2'b10, 1'b0, 32'h8000_1004, 32'h0, 0, 1'b0);          // op 11 is a no-op
    access(2'b01, 2'b11, 1'b0, 32'h8000_1004, 32'h0, 0, 1'b0);          // reserved size

    access(2'b01, 2'b10, 1'b0, 32'h8000_1020, 32'h0, 0, 1'b1);          // timeout
    slave_late = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1;
      check("late_ack_bus_req", 32'(bus_req), 32'd0);
      check("late_ack_stall", 32'(core_stall), 32'd0);
    end
    slave_late = 1'b0;

    // Reset in the middle of a stalled request.
    @(negedge clk);
    slave_hold = 1'b1;
    core_op = 2'b01; core_size = 2'b10; core_unsigned = 1'b0; core_addr = 32'h8000_1014;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("pre_reset_bus_req", 32'(bus_req), 32'd1);
    #1;
    reset_n = 1'b0;
    #1;
    check("async_reset_bus_req", 32'(bus_req), 32'd0);
    core_op = 2'b00;
    #1;
    check("reset_stall", 32'(core_stall), 32'd0);
    check("reset_rdata", core_rdata, 32'h0);
    check("reset_bus_be", 32'(bus_be), 32'h0);
    check("reset_bus_we", 32'(bus_we), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    slave_hold = 1'b0;
    last_load = 32'h0;
    access(2'b01, 2'b01, 1'b0, 32'h8000_1012, 32'h0, 2, 1'b0);          // normal after reset

    for (int t = 0; t < 200; t++) begin
      access(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             BASE + 32'($urandom_range(0, 79)), $urandom, int'($urandom_range(0, 3)), 1'b0);
    end

    repeat (3) @(negedge clk);
    check("resp_queue_drained", 32'(resp_q.size()), 32'd0);
    check("bus_queue_drained", 32'(bus_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rv32i_lsu.md
# rv32i_lsu

Load/store unit between the rv32i core's execute stage and an external data bus (bridge to SDRAM/BRAM/peripherals). It takes the core's per-instruction memory request (address, size, signedness, store data) and converts it into a word-aligned bus transaction with byte enables. It stalls the core until the bus acknowledges. It returns sign/zero-extended load data, and flags misaligned accesses and bus timeouts instead of issuing them.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255, max cycles bus_req may wait for bus_ack before a timeout fault; 0 disables the timeout.

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- core_op  in  2  00 none, 01 load, 10 store, 11 treated as none
- core_size  in  2  00 byte, 01 half, 10 word, 11 reserved (faults)
- core_unsigned  in  1  load zero-extends when 1 (LBU/LHU)
- core_addr  in  32  byte address (ALU result)
- core_wdata  in  32  store data (rs2), low bits significant
- core_stall  out  1  core must hold PC and all core_* inputs while 1
- core_rdata  out  32  extended load data, valid with core_rdata_valid
- core_rdata_valid  out  1  one-cycle pulse on load completion
- core_fault  out  1  one-cycle pulse: access aborted, no register/memory effect
- core_fault_cause  out  2  01 load misaligned, 10 store misaligned, 11 bus timeout; 00 otherwise
- bus_req  out  1  transaction request, held until bus_ack
- bus_we  out  1  1 write, 0 read
- bus_addr  out  32  {core_addr[31:2], 2'b00}
- bus_be  out  4  byte enables (reads drive the same lanes)
- bus_wdata  out  32  lane-replicated store data
- bus_ack  in  1  completion; may assert in the same cycle bus_req first rises
- bus_rdata  in  32  read data, sampled when bus_req && bus_ack && !bus_we

## Operation
- FSM states: IDLE, REQ, DONE, FAULT.
- IDLE: when core_op is load/store, core_stall=1 (combinational).
  - Aligned: latch we/addr/be/wdata/size/unsigned into bus registers, go to REQ.
  - Misaligned: go to FAULT with cause 01 (load) or 10 (store). Misaligned means size 11, half with addr[0]=1, or word with addr[1:0]!=0.
- REQ: bus_req=1, core_stall=1, timeout counter increments each cycle.
  - On bus_ack: a load registers the extracted data into core_rdata; go to DONE.
  - With no ack and counter reaching TIMEOUT_CYCLES (and TIMEOUT_CYCLES!=0): deassert bus_req, go to FAULT with cause 11.
- DONE: core_stall=0, core_rdata_valid=1 for loads only. Next state is IDLE. The core commits this cycle, so the same request is not re-issued.
- FAULT: core_stall=0, core_fault=1, core_fault_cause valid; next state IDLE, cause cleared to 00.
- Byte enables:
  - byte: 4'b0001 << addr[1:0]
  - half: addr[1] ? 1100 : 0011
  - word: 1111
- Store data: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
- Load extraction:
  - byte selects lane addr[1:0]; half selects addr[1] ? [31:16] : [15:0].
  - Sign-extend from bit 7/15 unless core_unsigned; word is passed through.
- bus_ack outside REQ is ignored. Timeout counter clears on entry to REQ. Counter width is clog2(TIMEOUT_CYCLES+1).
- core_op 11 behaves as none: no stall, no fault.

## Timing
- Reset (async, immediate) values:
  - state IDLE; counter 0
  - bus_req, bus_we 0; bus_addr, bus_be, bus_wdata 0
  - core_rdata 0; core_rdata_valid, core_fault 0; core_fault_cause 00
  - core_stall follows IDLE decode.
- Reset mid-REQ drops bus_req asynchronously; the in-flight bus ack is ignored after reset.
- Minimum access is 3 cycles, with zero-wait ack: IDLE (stall) -> REQ (req+ack) -> DONE (stall=0, valid).
  - Each bus wait cycle adds 1.
  - Misaligned access is 2 cycles: IDLE -> FAULT.
- Timeout with TIMEOUT_CYCLES=N: bus_req high exactly N cycles, then FAULT for 1 cycle.
- Bus outputs are registered and stable for the whole REQ phase. core_rdata holds its value until the next load completes.

## Test plan
- Load word at 0x8000_1004, bus_ack in first REQ cycle, bus_rdata=0xDEAD_BEEF -> bus_addr=0x8000_1004, be=1111, we=0. core_stall high 2 cycles. core_rdata=0xDEAD_BEEF with valid pulse in cycle 3.
- LB addr[1:0]=3, then LBU at the same address, bus_rdata=0x80xx_xxxx -> be=1000 both times. Results 0xFFFF_FF80 then 0x0000_0080.
- Store half at 0x...2, wdata=0x1234_ABCD, ack after 3 wait cycles -> be=1100, bus_wdata=0xABCD_ABCD, we=1. Stall high 5 cycles. No rdata_valid.
- Store word at addr ending 0x1, then LH at addr ending 0x3 -> bus_req never rises. Fault pulses with cause 10, then 01; 2 cycles each.
- TIMEOUT_CYCLES=4, load, bus_ack held low -> bus_req high exactly 4 cycles. Then core_fault=1, cause 11, stall=0. A late ack after that is ignored.
- Assert reset_n low during REQ -> bus_req falls without a clock. After release, state is IDLE and all outputs are 0. A new load completes normally.
